// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types, constants and helpers for the instruction-fetch stage
//
// Contents:
//   PC_STEP        byte distance between sequential instructions
//   fetch_entry_t  default queue entry layout {pc_plus4, instr} for a 32-bit core
//   ptr_w()        pointer width for a queue of a given depth
package if_pkg;

  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  // A one-entry queue still needs a one-bit pointer to keep the vectors legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - circular prefetch queue with push, pop, flush and occupancy count
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   flush       empties the queue; wins over push and pop in the same cycle
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         retire the head entry (ignored when empty)
//   head        entry at the head of the queue
//   count       number of stored entries, 0..DEPTH
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  entry_t                push_data,
  input  logic                  pop,
  output entry_t                head,
  output logic [ptr_w(DEPTH):0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap at DEPTH by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; count alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - instruction-fetch stage with a DEPTH-entry prefetch queue
//
// Optional feature macro: IF_PERF_COUNTERS_EN (stall/flush performance counters).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   branch_taken    redirect request from EX; flushes queue and in-flight read
//   branch_addr     redirect target
//   out_ready       ID accepts the head entry
//   imem_req        instruction memory read request this cycle
//   imem_addr       read address (the fetch PC)
//   imem_rdata      read data for the request issued the previous cycle
//   out_valid       head entry valid
//   out_pc          head instruction address + 4
//   out_instr       head instruction
//   perf_stall_cnt  cycles with out_valid && !out_ready (saturating)
//   perf_flush_cnt  branch flushes taken (saturating)
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               out_ready,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
);

  localparam int CW = ptr_w(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic              credit;
  entry_t            head;
  entry_t            push_data;

  // Slots already promised (stored + in flight) must stay below DEPTH; a pop
  // in the same cycle does not free a slot early.
  assign credit    = (count + CW'(inflight)) < CW'(DEPTH);
  assign imem_req  = !rst && !branch_taken && credit;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      if (branch_taken)  fetch_pc <= branch_addr;
      else if (imem_req) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      inflight <= imem_req;
    end
  end

  // fetch_pc was stepped when the in-flight read issued and cannot have moved
  // since (a redirect clears inflight), so it already equals request address + 4.
  assign push_data.pc_plus4 = fetch_pc;
  assign push_data.instr    = imem_rdata;

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (inflight),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .head      (head),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc_plus4 : '0;
  assign out_instr = out_valid ? head.instr    : '0;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken && (flush_cnt != '1))            flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
